// File: rtl/ym_ch_accum_gen_if.sv
// Operator-side inputs and mixer-side outputs of the channel accumulator.
// The debug port pair is present only when YM_CH_DEBUG_EN is defined.
interface ym_ch_accum_gen_if #(
  parameter int CH_COUNT  = 6,
  parameter int OP_WIDTH  = 9,
  parameter int OUT_WIDTH = 9
);
  localparam int IDX_W = $clog2(CH_COUNT);

  logic                   ce;
  logic                   sync;
  logic [OP_WIDTH-1:0]    op_value;
  logic                   op_out;
  logic                   dac_en;
  logic [7:0]             dac;
  logic                   dac_lsb;
  logic [2*CH_COUNT-1:0]  pan;
  logic [OUT_WIDTH-1:0]   ch_out;
  logic [IDX_W-1:0]       ch_idx;
  logic                   ch_valid;
  logic [1:0]             ch_pan;
`ifdef YM_CH_DEBUG_EN
  logic [IDX_W-1:0]       dbg_sel;
  logic [OUT_WIDTH-1:0]   ch_dbg;

  modport master (
    output ce, sync, op_value, op_out, dac_en, dac, dac_lsb, pan, dbg_sel,
    input  ch_out, ch_idx, ch_valid, ch_pan, ch_dbg
  );
  modport slave (
    input  ce, sync, op_value, op_out, dac_en, dac, dac_lsb, pan, dbg_sel,
    output ch_out, ch_idx, ch_valid, ch_pan, ch_dbg
  );
`else
  modport master (
    output ce, sync, op_value, op_out, dac_en, dac, dac_lsb, pan,
    input  ch_out, ch_idx, ch_valid, ch_pan
  );
  modport slave (
    input  ce, sync, op_value, op_out, dac_en, dac, dac_lsb, pan,
    output ch_out, ch_idx, ch_valid, ch_pan
  );
`endif
endinterface

// File: rtl/ym_ch_accum_gen.sv
// Time-multiplexed FM channel accumulator with saturating adds, PCM DAC override and pan tagging.
// Optional per-channel readback of the last emitted result when YM_CH_DEBUG_EN is defined.
module ym_ch_accum_gen #(
  parameter int CH_COUNT   = 6,
  parameter int OPS_PER_CH = 4,
  parameter int OP_WIDTH   = 9,
  parameter int OUT_WIDTH  = 9,
  parameter int DAC_CH     = 5
) (
  input logic MCLK,
  input logic IC,
  ym_ch_accum_gen_if.slave bus
);
  localparam int IDX_W = $clog2(CH_COUNT);
  localparam int OP_W  = (OPS_PER_CH > 1) ? $clog2(OPS_PER_CH) : 1;

  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(CH_COUNT - 1);
  localparam logic [OP_W-1:0]  LAST_OP = OP_W'(OPS_PER_CH - 1);
  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_ZERO = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic signed [OUT_WIDTH-1:0] sat_add(
    input logic signed [OUT_WIDTH-1:0] a,
    input logic signed [OUT_WIDTH-1:0] b
  );
    logic [OUT_WIDTH:0] s;
    s = {a[OUT_WIDTH-1], a} + {b[OUT_WIDTH-1], b};
    if (s[OUT_WIDTH] != s[OUT_WIDTH-1]) return s[OUT_WIDTH] ? SAT_MIN : SAT_MAX;
    return s[OUT_WIDTH-1:0];
  endfunction

  logic [IDX_W-1:0]              ch_cnt, cur_ch, nxt_ch;
  logic [OP_W-1:0]               op_cnt, cur_op, nxt_op;
  logic signed [OUT_WIDTH-1:0]   acc [CH_COUNT];
  logic signed [OP_WIDTH-1:0]    op_s;
  logic signed [OUT_WIDTH-1:0]   m, base, sum, r;
  logic [8:0]                    dac_word9;
  logic [OUT_WIDTH-1:0]          dac_word;
  logic                          finish;

  logic [OUT_WIDTH-1:0]          ch_out_q;
  logic [IDX_W-1:0]              ch_idx_q;
  logic [1:0]                    ch_pan_q;
  logic                          ch_valid_q;

  // sync re-aligns the current input to slot 0; it only matters when ce advances the slot
  always_comb begin
    cur_ch = bus.sync ? '0 : ch_cnt;
    cur_op = bus.sync ? '0 : op_cnt;
    nxt_ch = cur_ch + 1'b1;
    nxt_op = cur_op;
    if (cur_ch == LAST_CH) begin
      nxt_ch = '0;
      nxt_op = (cur_op == LAST_OP) ? '0 : cur_op + 1'b1;
    end
    finish = (cur_op == LAST_OP);

    op_s = bus.op_value;
    m    = bus.op_out ? OUT_WIDTH'(op_s) : '0;
    // op 0 starts a fresh sum; the previous one has already been emitted
    base = (cur_op == '0) ? '0 : acc[cur_ch];
    sum  = sat_add(base, m);

    dac_word9 = {~bus.dac[7], bus.dac[6:0], bus.dac_lsb};
    dac_word  = OUT_WIDTH'(dac_word9) << (OUT_WIDTH - 9);
    r = (bus.dac_en && (int'(cur_ch) == DAC_CH)) ? signed'(dac_word) : sum;
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      ch_cnt     <= '0;
      op_cnt     <= '0;
      for (int i = 0; i < CH_COUNT; i++) acc[i] <= '0;
      ch_out_q   <= OUT_ZERO;
      ch_idx_q   <= '0;
      ch_pan_q   <= '0;
      ch_valid_q <= 1'b0;
    end else begin
      ch_valid_q <= 1'b0;
      if (bus.ce) begin
        ch_cnt      <= nxt_ch;
        op_cnt      <= nxt_op;
        acc[cur_ch] <= sum;
        if (finish) begin
          ch_out_q   <= {~r[OUT_WIDTH-1], r[OUT_WIDTH-2:0]};
          ch_idx_q   <= cur_ch;
          ch_pan_q   <= bus.pan[{cur_ch, 1'b0} +: 2];
          ch_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ch_out   = ch_out_q;
  assign bus.ch_idx   = ch_idx_q;
  assign bus.ch_pan   = ch_pan_q;
  assign bus.ch_valid = ch_valid_q;

`ifdef YM_CH_DEBUG_EN
  logic signed [OUT_WIDTH-1:0] dbg_hold [CH_COUNT];
  logic [OUT_WIDTH-1:0]        ch_dbg_q;

  // readback follows dbg_sel every clock, independent of ce
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      for (int i = 0; i < CH_COUNT; i++) dbg_hold[i] <= '0;
      ch_dbg_q <= '0;
    end else begin
      if (bus.ce && finish) dbg_hold[cur_ch] <= r;
      ch_dbg_q <= ({1'b0, bus.dbg_sel} < (IDX_W+1)'(CH_COUNT)) ? dbg_hold[bus.dbg_sel] : '0;
    end
  end

  assign bus.ch_dbg = ch_dbg_q;
`endif
endmodule

// File: tb/tb_ym_ch_accum_gen.sv
// Self-checking bench for ym_ch_accum_gen: per-pass vector table, slot-level scoreboard, corner sequences.
module tb_ym_ch_accum_gen;
  localparam int CH  = 6;
  localparam int OPS = 4;
  localparam int NS  = CH * OPS;

  logic MCLK = 1'b0;
  logic IC   = 1'b0;
  always #5 MCLK = ~MCLK;

  ym_ch_accum_gen_if #(.CH_COUNT(CH), .OP_WIDTH(9), .OUT_WIDTH(9))  bus ();
  ym_ch_accum_gen_if #(.CH_COUNT(CH), .OP_WIDTH(9), .OUT_WIDTH(12)) bus12 ();

  assign bus12.ce       = bus.ce;
  assign bus12.sync     = bus.sync;
  assign bus12.op_value = bus.op_value;
  assign bus12.op_out   = bus.op_out;
  assign bus12.dac_en   = bus.dac_en;
  assign bus12.dac      = bus.dac;
  assign bus12.dac_lsb  = bus.dac_lsb;
  assign bus12.pan      = bus.pan;
`ifdef YM_CH_DEBUG_EN
  assign bus12.dbg_sel  = bus.dbg_sel;
`endif

  ym_ch_accum_gen #(.CH_COUNT(CH), .OPS_PER_CH(OPS), .OP_WIDTH(9), .OUT_WIDTH(9), .DAC_CH(5))
    dut (.MCLK(MCLK), .IC(IC), .bus(bus));
  ym_ch_accum_gen #(.CH_COUNT(CH), .OPS_PER_CH(OPS), .OP_WIDTH(9), .OUT_WIDTH(12), .DAC_CH(5))
    dut12 (.MCLK(MCLK), .IC(IC), .bus(bus12));

  typedef struct packed {
    logic [8:0] out;
    logic [2:0] idx;
    logic [1:0] pan;
    int         cyc;
  } exp_t;

  typedef struct packed {
    int             ch;
    logic [3:0][8:0] ops;
    logic [3:0]     mask;
    logic           dac_en;
    logic [7:0]     dac;
    logic           lsb;
    logic [8:0]     exp;
  } rec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_strobe = 0;
  exp_t sbq[$];
  int m_s;
  int m_acc [CH];
  int pv [NS];
  bit po [NS];
  logic [8:0]  last_out [CH];
  logic [11:0] last12 [CH];
  rec_t tbl [10];

  always @(posedge MCLK) cyc <= cyc + 1;

  function automatic rec_t mk(input int ch, input int o0, input int o1, input int o2, input int o3,
                              input logic [3:0] mask, input logic den, input logic [7:0] d,
                              input logic l, input logic [8:0] e);
    rec_t rc;
    rc.ch = ch;
    rc.ops[0] = 9'(o0); rc.ops[1] = 9'(o1); rc.ops[2] = 9'(o2); rc.ops[3] = 9'(o3);
    rc.mask = mask; rc.dac_en = den; rc.dac = d; rc.lsb = l; rc.exp = e;
    return rc;
  endfunction

  function automatic int clamp9(input int x);
    return (x > 255) ? 255 : ((x < -256) ? -256 : x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One slot: drive inputs, advance the reference model, push any finish result.
  task automatic slot(input int v, input bit o, input bit c, input bit sy);
    int s, ch, op, mv, r;
    exp_t e;
    bus.op_value = 9'(v);
    bus.op_out   = o;
    bus.ce       = c;
    bus.sync     = sy;
    bus.pan      = 12'($urandom);
    if (c) begin
      s  = sy ? 0 : m_s;
      ch = s % CH;
      op = s / CH;
      mv = o ? v : 0;
      m_acc[ch] = (op == 0) ? mv : clamp9(m_acc[ch] + mv);
      if (op == OPS - 1) begin
        r = m_acc[ch];
        if (bus.dac_en && ch == 5) r = int'(bus.dac) * 2 + int'(bus.dac_lsb) - 256;
        e.out = 9'(r + 256);
        e.idx = 3'(ch);
        e.pan = bus.pan[2*ch +: 2];
        e.cyc = cyc + 1;
        sbq.push_back(e);
      end
      m_s = (s + 1) % NS;
    end
    @(negedge MCLK);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) slot(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_rec(input rec_t rc);
    for (int s = 0; s < NS; s++) begin
      pv[s] = 0;
      po[s] = 1'b1;
    end
    for (int op = 0; op < OPS; op++) begin
      pv[op*CH + rc.ch] = int'(signed'(rc.ops[op]));
      po[op*CH + rc.ch] = rc.mask[op];
    end
    bus.dac_en  = rc.dac_en;
    bus.dac     = rc.dac;
    bus.dac_lsb = rc.lsb;
  endtask

  task automatic run_pass(input bit sy0, input int stall_at);
    for (int s = 0; s < NS; s++) begin
      if (s == stall_at)
        for (int k = 0; k < 3; k++) slot(0, 1'b0, 1'b0, k == 1);
      slot(pv[s], po[s], 1'b1, sy0 && s == 0);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge MCLK);
      if (bus.ch_valid === 1'b1) begin
        n_strobe++;
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_strobe: ch_idx=%0d ch_out=%h at cyc %0d, expected no strobe",
                   bus.ch_idx, bus.ch_out, cyc);
        end else begin
          e = sbq.pop_front();
          if (bus.ch_out !== e.out || bus.ch_idx !== e.idx || bus.ch_pan !== e.pan || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL strobe_ch%0d: got out=%h idx=%0d pan=%b cyc=%0d, expected out=%h idx=%0d pan=%b cyc=%0d",
                     e.idx, bus.ch_out, bus.ch_idx, bus.ch_pan, cyc, e.out, e.idx, e.pan, e.cyc);
          end
        end
        if (bus.ch_idx < 3'(CH)) last_out[bus.ch_idx] = bus.ch_out;
      end
      if (bus12.ch_valid === 1'b1 && bus12.ch_idx < 3'(CH)) last12[bus12.ch_idx] = bus12.ch_out;
    end
  endtask

  initial begin
    int n0;
    bus.ce = 1'b0; bus.sync = 1'b0; bus.op_value = '0; bus.op_out = 1'b0;
    bus.dac_en = 1'b0; bus.dac = '0; bus.dac_lsb = 1'b0; bus.pan = '0;
`ifdef YM_CH_DEBUG_EN
    bus.dbg_sel = '0;
`endif
    m_s = 0;
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0; last_out[c] = '0; last12[c] = '0;
    end

    tbl[0] = mk(0,  100,   50,  -30,   10, 4'b1111, 1'b0, 8'h00, 1'b0, 9'h182);
    tbl[1] = mk(1,  200,  200,  200,  200, 4'b1111, 1'b0, 8'h00, 1'b0, 9'h1FF);
    tbl[2] = mk(2, -200, -200, -200, -200, 4'b1111, 1'b0, 8'h00, 1'b0, 9'h000);
    tbl[3] = mk(3,  255,  255, -255, -255, 4'b1111, 1'b0, 8'h00, 1'b0, 9'h001);
    tbl[4] = mk(0,  100,   50,  -30,   10, 4'b0101, 1'b0, 8'h00, 1'b0, 9'h146);
    tbl[5] = mk(5,    0,    0,    0,    0, 4'b1111, 1'b1, 8'h80, 1'b1, 9'h101);
    tbl[6] = mk(5,    0,    0,    0,    0, 4'b1111, 1'b1, 8'h00, 1'b0, 9'h000);
    tbl[7] = mk(5,   10,   20,   30,   40, 4'b1111, 1'b0, 8'h80, 1'b1, 9'h164);
    tbl[8] = mk(4,   -1,   -1,   -1,   -1, 4'b1111, 1'b1, 8'h40, 1'b0, 9'h0FC);
    tbl[9] = mk(3,  255,  255, -255,    0, 4'b1111, 1'b0, 8'h00, 1'b0, 9'h100);

    fork
      monitor();
    join_none

    repeat (3) @(negedge MCLK);
    chk("rst_ch_out",   bus.ch_out,   9'h100);
    chk("rst_ch_valid", bus.ch_valid, 1'b0);
    chk("rst_ch_idx",   bus.ch_idx,   3'd0);
    chk("rst_ch_pan",   bus.ch_pan,   2'b00);
    chk("rst_w12_out",  bus12.ch_out, 12'h800);
    IC = 1'b1;
    @(negedge MCLK);

    for (int i = 0; i < 10; i++) begin
      load_rec(tbl[i]);
      run_pass(1'b1, -1);
      idle(2);
      chk($sformatf("tbl%0d_ch%0d", i, tbl[i].ch), last_out[tbl[i].ch], tbl[i].exp);
    end

    // reset in the middle of a pass with a nonzero ch0 partial sum
    load_rec(tbl[1]);
    pv[0] = 150; pv[6] = 90;
    for (int s = 0; s <= 10; s++) slot(pv[s], po[s], 1'b1, s == 0);
    IC = 1'b0;
    #1;
    chk("midrst_ch_out",   bus.ch_out,   9'h100);
    chk("midrst_ch_valid", bus.ch_valid, 1'b0);
    chk("midrst_ch_idx",   bus.ch_idx,   3'd0);
    chk("midrst_ch_pan",   bus.ch_pan,   2'b00);
    @(negedge MCLK);
    IC = 1'b1;
    m_s = 0;
    for (int c = 0; c < CH; c++) m_acc[c] = 0;
    load_rec(mk(0, -50, 20, 20, 5, 4'b1111, 1'b0, 8'h00, 1'b0, 9'h0FB));
    run_pass(1'b0, -1);
    idle(2);
    chk("postrst_ch0", last_out[0], 9'h0FB);

    // ce low for three cycles on ch0's finish slot, with a stray sync while ce is low
    load_rec(tbl[0]);
    n0 = n_strobe;
    run_pass(1'b1, 18);
    idle(2);
    chk("stall_strobes", n_strobe - n0, CH);
    chk("stall_ch0", last_out[0], 9'h182);

    // sync arriving at slot 7 restarts the pass there
    load_rec(tbl[1]);
    for (int s = 0; s < 7; s++) slot(5, 1'b1, 1'b1, 1'b0);
    run_pass(1'b1, -1);
    idle(2);
    chk("sync7_ch1", last_out[1], 9'h1FF);

    // 12-bit build: left-justified DAC word and wider offset-binary sum
    load_rec(mk(0, 100, 50, -30, 10, 4'b1111, 1'b1, 8'hFF, 1'b1, 9'h182));
    last12[0] = '0; last12[5] = '0;
    run_pass(1'b1, -1);
    idle(2);
    chk("w12_ch0",     last12[0],   12'h882);
    chk("w12_dac_ch5", last12[5],   12'hFF8);
    chk("w9_dac_ch5",  last_out[5], 9'h1FF);

    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
